// File: rtl/dmem_signature_unit.sv
// Data-memory slave: word RAM with byte-lane stores, signature FIFO of stores into a window, TOHOST end-of-test.
// Build option DMEM_BYTE_WEN_EN: allow partial byte-enable stores; otherwise only wen==1111 writes.
module dmem_signature_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] SIG_BASE    = 32'h0000_0100,
    parameter int unsigned SIG_WORDS   = 16,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wen,
    output logic [31:0] d_mem_rdata,
    output logic        sig_valid,
    input  logic        sig_ready,
    output logic [7:0]  sig_index,
    output logic [31:0] sig_data,
    output logic [7:0]  drop_cnt,
    output logic        err,
    output logic        done,
    output logic [31:0] done_code
);
    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam int unsigned FW         = $clog2(FIFO_DEPTH);
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] SIG_END    = SIG_BASE + 32'(4 * SIG_WORDS);
    localparam logic [FW:0] FULL_CNT   = (FW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]  index;
        logic [31:0] data;
    } sig_entry_t;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    logic [31:0]   mem_q [DEPTH_WORDS];
    sig_entry_t    fifo_q [FIFO_DEPTH];
    logic [FW-1:0] rd_ptr_q, wr_ptr_q;
    logic [FW:0]   count_q, count_d;
    logic [7:0]    drop_q;
    logic          err_q, done_q;
    logic [31:0]   done_code_q;
    state_t        state_q;

    logic          in_range, wr_en, bad_wen, err_set, sig_hit, tohost_hit;
    logic          full, pop, push_ok;
    logic [3:0]    lanes;
    logic [AW-1:0] widx;
    logic [31:0]   old_word, merged, sig_off;
    logic [7:0]    sig_idx;

    assign in_range    = d_mem_addr < BYTE_LIMIT;
    assign widx        = d_mem_addr[AW+1:2];
    assign old_word    = mem_q[widx];
    assign d_mem_rdata = in_range ? old_word : '0;

`ifdef DMEM_BYTE_WEN_EN
    assign lanes   = d_mem_wen;
    assign bad_wen = 1'b0;
`else
    assign lanes   = (d_mem_wen == 4'hF) ? 4'hF : 4'h0;
    assign bad_wen = (d_mem_wen != 4'h0) && (d_mem_wen != 4'hF);
`endif

    assign wr_en   = in_range && (lanes != 4'h0);
    assign err_set = ((d_mem_wen != 4'h0) && !in_range) || bad_wen ||
                     ((d_mem_wen == 4'hF) && (d_mem_addr[1:0] != 2'b00));

    // Post-store word is formed from the current RAM word so the log needs no extra read cycle.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) merged[8*i +: 8] = d_mem_wdata[8*i +: 8];
    end

    assign sig_off    = d_mem_addr - SIG_BASE;
    assign sig_idx    = 8'(sig_off >> 2);
    assign sig_hit    = wr_en && (d_mem_addr >= SIG_BASE) && (d_mem_addr < SIG_END);
    assign tohost_hit = wr_en && (d_mem_addr == TOHOST_ADDR);

    assign full    = count_q == FULL_CNT;
    assign pop     = (count_q != '0) && sig_ready;
    assign push_ok = sig_hit && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[widx] <= merged;
        if (push_ok) fifo_q[wr_ptr_q] <= '{index: sig_idx, data: merged};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (sig_hit && full && !pop && (drop_q != 8'hFF)) drop_q <= drop_q + 1'b1;
            if (err_set) err_q <= 1'b1;
        end
    end

    // A push landing while the FIFO is empty keeps DRAIN alive until that entry is consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            done_code_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: if (tohost_hit) begin
                    state_q     <= ST_DRAIN;
                    done_code_q <= d_mem_wdata;
                end
                ST_DRAIN: if ((count_q == '0) && !sig_hit) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sig_valid = count_q != '0;
    assign sig_index = fifo_q[rd_ptr_q].index;
    assign sig_data  = fifo_q[rd_ptr_q].data;
    assign drop_cnt  = drop_q;
    assign err       = err_q;
    assign done      = done_q;
    assign done_code = done_code_q;
endmodule

// File: doc/dmem_signature_unit.md
Name: dmem_signature_unit

Overview:
Synthesizable data-memory slave on the CPU data port (d_mem_*), downstream of cpu_top's MEM stage; replaces the behavioural data-memory model in the directed test benches.
Provides word RAM with byte-lane writes and combinational read, matching the CPU's single-cycle load interface.
Logs every store into a signature window through a streaming FIFO, and flags end-of-test on a write to a TOHOST address.
Benches check PASS/FAIL from the signature stream instead of peeking at memory arrays.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words; byte range is 0 to 4*DEPTH_WORDS-1.
SIG_BASE, 32'h0000_0100, byte address of signature window word 0.
SIG_WORDS, 16, signature window size in words; power of two, at most 256.
TOHOST_ADDR, 32'h0000_0FFC, word-aligned end-of-test mailbox address.
FIFO_DEPTH, 8, signature FIFO entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low.
d_mem_addr  in  32  byte address from CPU.
d_mem_wdata  in  32  store data, already lane-aligned by CPU.
d_mem_wen  in  4  byte-lane write enables; 0000 means no store.
d_mem_rdata  out  32  combinational read data.
sig_valid  out  1  FIFO head valid.
sig_ready  in  1  consumer accepts head.
sig_index  out  8  word offset of the logged store within the window.
sig_data  out  32  full RAM word after the store was applied.
drop_cnt  out  8  saturating count of signature entries lost to a full FIFO.
err  out  1  sticky access error.
done  out  1  end of test, signature drained.
done_code  out  32  value written to TOHOST.

Behaviour:
- Reset (rst_n=0 at clk edge): sig_valid=0, FIFO empty, drop_cnt=0, err=0, done=0, done_code=0, FSM=RUN. RAM contents are not reset.
- Read path:
  - d_mem_rdata = RAM[addr[31:2]] combinationally when addr < 4*DEPTH_WORDS; otherwise 0.
  - addr[1:0] is ignored for reads.
  - A read in the same cycle as a store to the same word returns the old data. The new data is visible from the next cycle.
- Write path (on clk edge when wen != 0):
  - In range: each set lane i writes wdata[8i+7:8i].
  - Out of range: RAM unchanged, err set.
  - wen==1111 with addr[1:0]!=0: write still performed at the word address, err set.
- Signature logging:
  - Any in-range store with SIG_BASE <= addr < SIG_BASE+4*SIG_WORDS pushes {index = (addr-SIG_BASE)>>2, data = merged post-write word}.
  - The merged word is computed from the old RAM word and the written lanes in the same cycle; there is no extra read cycle.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full: the pop frees a slot and the push is accepted.
  - Push while full without a pop: entry dropped, drop_cnt increments and saturates at 255.
  - Pop occurs when sig_valid && sig_ready. sig_index/sig_data hold stable while sig_valid && !sig_ready.
  - Ordering is strict FIFO.
- FSM (RUN, DRAIN, DONE):
  - RUN: in-range store to TOHOST_ADDR latches done_code=wdata (full word regardless of wen) and moves to DRAIN. The RAM write still occurs.
  - DRAIN: when the FIFO is empty, moves to DONE the next edge.
  - DONE: done=1 and held until reset.
  - After RUN, further TOHOST writes do not change done_code. Signature pushes continue in DRAIN and DONE; a push in DRAIN delays DONE until drained.
- Reset mid-operation clears the FIFO, counters and FSM immediately; entries already stored in RAM remain.

Optional Feature:
Macro: DMEM_BYTE_WEN_EN.
- Defined: partial byte enables (0001, 0011, 1100, etc.) write the selected lanes as specified above.
- Undefined: only wen==1111 writes RAM and logs a signature entry. Any other non-zero wen is ignored and sets err.
- TOHOST detection requires wen==1111 when undefined.

Test Plan:
1. Store 0x00000F00 (wen 1111) to 0x100 with sig_ready=1 -> next cycle sig_valid=1, sig_index=0, sig_data=0x00000F00; rdata at 0x100 = 0x00000F00; err=0.
2. Store 0xF8000000 to 0x108, then 0xFFFFFFE7 to 0x114 -> entries (2, 0xF8000000) then (5, 0xFFFFFFE7) in order.
3. Hold sig_ready=0 and store 10 words into the window -> 8 entries queued, drop_cnt=2, the first 8 entries are retained in order. Then a push with a simultaneous pop while full -> accepted, drop_cnt stays 2.
4. With DMEM_BYTE_WEN_EN, word 0x104 = 0x11223344; store wdata 0x0000AA00 with wen 0010 -> RAM word 0x1122AA44, signature (1, 0x1122AA44). Without the macro -> RAM unchanged, no entry, err=1.
5. Two entries pending, then store 0x1 to 0xFFC -> done_code=1, done stays 0 until both entries popped, rises the edge after empty. A later store of 0x2 to 0xFFC leaves done_code=1.
6. Store to 0x1000 -> err=1, RAM unchanged, rdata at 0x1000 = 0. Assert rst_n=0 for one edge in DRAIN -> done=0, err=0, FIFO empty, FSM=RUN.
